// File: rtl/spu_sm_ctrl.sv
// spu_sm_ctrl: sequencer for the softmax SPU datapath.
// For one token row it issues buffer reads and in-place write-backs over three passes
// (MAX, EU_STAGE_A exp, EU_STAGE_B normalise), with a reciprocal handshake between
// the exp pass and the normalise pass.
//
// Cycle count from the accept cycle to the done cycle, with N = token_len and
// W = number of RECI_WAIT cycles (W >= 1):
//   (N+RD_LAT+1) + (N+RD_LAT+EXP_LAT+ADD_LAT) + 1 + W + (N+RD_LAT+OUT_LAT) + 1
// token_len = 0 completes with done one cycle after accept.
//
// comp_rst / sum_clr are decoded from start in the accept cycle itself so that the
// comparator and adder tree are clear before the first word arrives. Every other
// output comes from a flop. RD_LAT must be >= 1.
module spu_sm_ctrl #(
    parameter int AW      = 10,
    parameter int LW      = 10,
    parameter int RD_LAT  = 1,
    parameter int EXP_LAT = 2,
    parameter int ADD_LAT = 3,
    parameter int OUT_LAT = 2
) (
    input  logic          core_clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] base_addr,
    input  logic [LW-1:0] token_len,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [2:0]    sm_state,
    output logic          comp_en,
    output logic          comp_rst,
    output logic          adder_tree_en,
    output logic          sum_clr,
    output logic          reci_exp_sum_en,
    input  logic          reci_exp_sum_finish
);

    // Read-to-write distances for the two writing passes
    localparam int DA = RD_LAT + EXP_LAT;
    localparam int DB = RD_LAT + OUT_LAT;
    localparam int PL = (DA > DB) ? DA : DB;
    localparam int CW = $clog2(DA + DB + ADD_LAT + RD_LAT + 2) + 1;

    localparam logic [CW-1:0] MAX_DRN_LAST  = CW'(RD_LAT);
    localparam logic [CW-1:0] EXPA_DRN_LAST = CW'(DA + ADD_LAT - 1);
    localparam logic [CW-1:0] EXPB_DRN_LAST = CW'(DB - 1);

    localparam logic [2:0] SM_IDLE = 3'b000;
    localparam logic [2:0] SM_EXPA = 3'b001;
    localparam logic [2:0] SM_RECI = 3'b011;
    localparam logic [2:0] SM_EXPB = 3'b100;
    localparam logic [2:0] SM_MAX  = 3'b101;

    typedef enum logic [3:0] {
        S_IDLE,
        S_MAX_RD,
        S_MAX_DRN,
        S_EXPA_RD,
        S_EXPA_DRN,
        S_RECI_REQ,
        S_RECI_WAIT,
        S_EXPB_RD,
        S_EXPB_DRN
    } state_t;

    state_t        state, state_nxt;
    logic          rd_en_nxt;
    logic [AW-1:0] rd_addr_nxt;
    logic [LW-1:0] rd_cnt, rd_cnt_nxt;
    logic [CW-1:0] drn_cnt, drn_cnt_nxt;
    logic          done_nxt;
    logic          reci_en_nxt;
    logic          fin_seen, fin_seen_nxt;
    logic [AW-1:0] base_q, base_nxt;
    logic [LW-1:0] len_q, len_nxt;
    logic          flush;
    logic          accept_go;

    // Per-pass valid delay lines (index k = rd_en delayed k cycles) plus the address line
    logic [PL:1]         max_vld_pipe;
    logic [PL:1]         a_vld_pipe;
    logic [PL:1]         b_vld_pipe;
    logic [PL:1][AW-1:0] addr_pipe;

    function automatic logic [2:0] stage_code(input state_t s);
        case (s)
            S_MAX_RD, S_MAX_DRN:      stage_code = SM_MAX;
            S_EXPA_RD, S_EXPA_DRN:    stage_code = SM_EXPA;
            S_RECI_REQ, S_RECI_WAIT:  stage_code = SM_RECI;
            S_EXPB_RD, S_EXPB_DRN:    stage_code = SM_EXPB;
            default:                  stage_code = SM_IDLE;
        endcase
    endfunction

    // abort only acts outside IDLE; in IDLE it just suppresses start
    assign flush     = abort && (state != S_IDLE);
    assign accept_go = (state == S_IDLE) && start && !abort && (token_len != '0);
    assign comp_rst  = accept_go;
    assign sum_clr   = accept_go;

    // Next-state, read issue and handshake decode
    always_comb begin
        state_nxt    = state;
        rd_en_nxt    = 1'b0;
        rd_addr_nxt  = '0;
        rd_cnt_nxt   = rd_cnt;
        drn_cnt_nxt  = '0;
        done_nxt     = 1'b0;
        reci_en_nxt  = 1'b0;
        fin_seen_nxt = 1'b0;
        base_nxt     = base_q;
        len_nxt      = len_q;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        base_nxt = base_addr;
                        len_nxt  = token_len;
                        if (token_len == '0) begin
                            done_nxt = 1'b1;
                        end else begin
                            state_nxt   = S_MAX_RD;
                            rd_en_nxt   = 1'b1;
                            rd_addr_nxt = base_addr;
                            rd_cnt_nxt  = LW'(1);
                        end
                    end
                end
                S_MAX_RD, S_EXPA_RD, S_EXPB_RD: begin
                    // rd_cnt counts reads already on the bus, so the pass ends when it hits len
                    if (rd_cnt == len_q) begin
                        case (state)
                            S_MAX_RD:  state_nxt = S_MAX_DRN;
                            S_EXPA_RD: state_nxt = S_EXPA_DRN;
                            default:   state_nxt = S_EXPB_DRN;
                        endcase
                    end else begin
                        rd_en_nxt   = 1'b1;
                        rd_addr_nxt = rd_addr + 1'b1;
                        rd_cnt_nxt  = rd_cnt + 1'b1;
                    end
                end
                S_MAX_DRN: begin
                    if (drn_cnt == MAX_DRN_LAST) begin
                        state_nxt   = S_EXPA_RD;
                        rd_en_nxt   = 1'b1;
                        rd_addr_nxt = base_q;
                        rd_cnt_nxt  = LW'(1);
                    end else begin
                        drn_cnt_nxt = drn_cnt + 1'b1;
                    end
                end
                S_EXPA_DRN: begin
                    // wait out the last exp write plus the adder tree settling time
                    if (drn_cnt == EXPA_DRN_LAST) begin
                        state_nxt   = S_RECI_REQ;
                        reci_en_nxt = 1'b1;
                    end else begin
                        drn_cnt_nxt = drn_cnt + 1'b1;
                    end
                end
                S_RECI_REQ: begin
                    // a finish coincident with the request is remembered for RECI_WAIT
                    state_nxt    = S_RECI_WAIT;
                    fin_seen_nxt = reci_exp_sum_finish;
                end
                S_RECI_WAIT: begin
                    if (reci_exp_sum_finish || fin_seen) begin
                        state_nxt   = S_EXPB_RD;
                        rd_en_nxt   = 1'b1;
                        rd_addr_nxt = base_q;
                        rd_cnt_nxt  = LW'(1);
                    end
                end
                S_EXPB_DRN: begin
                    if (drn_cnt == EXPB_DRN_LAST) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        drn_cnt_nxt = drn_cnt + 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Control registers and registered outputs
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            rd_en           <= 1'b0;
            rd_addr         <= '0;
            rd_cnt          <= '0;
            drn_cnt         <= '0;
            done            <= 1'b0;
            busy            <= 1'b0;
            reci_exp_sum_en <= 1'b0;
            fin_seen        <= 1'b0;
            base_q          <= '0;
            len_q           <= '0;
            sm_state        <= SM_IDLE;
        end else begin
            state           <= state_nxt;
            rd_en           <= rd_en_nxt;
            rd_addr         <= rd_addr_nxt;
            rd_cnt          <= rd_cnt_nxt;
            drn_cnt         <= drn_cnt_nxt;
            done            <= done_nxt;
            busy            <= (state_nxt != S_IDLE) || done_nxt;
            reci_exp_sum_en <= reci_en_nxt;
            fin_seen        <= fin_seen_nxt;
            base_q          <= base_nxt;
            len_q           <= len_nxt;
            sm_state        <= stage_code(state_nxt);
        end
    end

    // Delay lines: shift every cycle, wiped on abort so no stale write escapes
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            max_vld_pipe <= '0;
            a_vld_pipe   <= '0;
            b_vld_pipe   <= '0;
            addr_pipe    <= '0;
        end else if (flush) begin
            max_vld_pipe <= '0;
            a_vld_pipe   <= '0;
            b_vld_pipe   <= '0;
            addr_pipe    <= '0;
        end else begin
            max_vld_pipe[1] <= rd_en && (state == S_MAX_RD);
            a_vld_pipe[1]   <= rd_en && (state == S_EXPA_RD);
            b_vld_pipe[1]   <= rd_en && (state == S_EXPB_RD);
            addr_pipe[1]    <= rd_addr;
            for (int k = 2; k <= PL; k++) begin
                max_vld_pipe[k] <= max_vld_pipe[k-1];
                a_vld_pipe[k]   <= a_vld_pipe[k-1];
                b_vld_pipe[k]   <= b_vld_pipe[k-1];
                addr_pipe[k]    <= addr_pipe[k-1];
            end
        end
    end

    assign comp_en       = max_vld_pipe[RD_LAT];
    assign adder_tree_en = a_vld_pipe[DA];
    assign wr_en         = a_vld_pipe[DA] | b_vld_pipe[DB];

    // Write address follows whichever writing pass is active; the passes never overlap
    always_comb begin
        wr_addr = '0;
        if (a_vld_pipe[DA]) begin
            wr_addr = addr_pipe[DA];
        end else if (b_vld_pipe[DB]) begin
            wr_addr = addr_pipe[DB];
        end
    end

endmodule

// File: tb/tb_spu_sm_ctrl.sv
// tb_spu_sm_ctrl: randomized bench for spu_sm_ctrl. Each operation's expected
// per-cycle outputs are computed from the pass schedule (window start times and
// lengths), then compared with the DUT on the falling edge.
module tb_spu_sm_ctrl;

    localparam int AW      = 10;
    localparam int LW      = 10;
    localparam int RD_LAT  = 1;
    localparam int EXP_LAT = 2;
    localparam int ADD_LAT = 3;
    localparam int OUT_LAT = 2;
    localparam int DA      = RD_LAT + EXP_LAT;
    localparam int DB      = RD_LAT + OUT_LAT;

    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_A    = 3'b001;
    localparam logic [2:0] ST_RECI = 3'b011;
    localparam logic [2:0] ST_B    = 3'b100;
    localparam logic [2:0] ST_MAX  = 3'b101;

    logic          core_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          finish = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] token_len = '0;
    logic          busy, done, rd_en, wr_en, comp_en, comp_rst, adder_tree_en, sum_clr, reci_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [2:0]    sm_state;

    int n_chk = 0;
    int n_err = 0;

    always #5 core_clk = ~core_clk;

    spu_sm_ctrl #(
        .AW(AW), .LW(LW), .RD_LAT(RD_LAT), .EXP_LAT(EXP_LAT), .ADD_LAT(ADD_LAT), .OUT_LAT(OUT_LAT)
    ) dut (
        .core_clk            (core_clk),
        .rst_n               (rst_n),
        .start               (start),
        .abort               (abort),
        .base_addr           (base_addr),
        .token_len           (token_len),
        .busy                (busy),
        .done                (done),
        .rd_en               (rd_en),
        .rd_addr             (rd_addr),
        .wr_en               (wr_en),
        .wr_addr             (wr_addr),
        .sm_state            (sm_state),
        .comp_en             (comp_en),
        .comp_rst            (comp_rst),
        .adder_tree_en       (adder_tree_en),
        .sum_clr             (sum_clr),
        .reci_exp_sum_en     (reci_en),
        .reci_exp_sum_finish (finish)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {busy, done, rd_en, wr_en, comp_en, comp_rst, adder_tree_en, sum_clr,
                reci_en, sm_state, rd_addr, wr_addr};
    endfunction

    function automatic bit in_win(input int t, input int s, input int n);
        return (t >= s) && (t < s + n);
    endfunction

    // One operation. kill_sel: 0 none, 1 in RECI_WAIT, 2 mid EXPB_RD, 3 mid MAX.
    // kill_rst selects async reset instead of abort. dup pulses start mid EXPA_RD.
    task automatic run_op(input logic [AW-1:0] base, input int len, input int fin_k,
                          input bit fin_hold, input bit dup, input int kill_sel, input bit kill_rst);
        int m0, e0, r0, b0, dn, w, t_end, dup_t, kill_t;
        int n_wa, n_wb, n_done, t_done;
        m0 = 1;
        e0 = m0 + len + RD_LAT + 1;
        r0 = e0 + len + DA + ADD_LAT;
        w  = fin_hold ? 1 : ((fin_k < 1) ? 1 : fin_k);
        b0 = r0 + 1 + w;
        dn = (len == 0) ? 1 : (b0 + len + DB);
        dup_t  = dup ? (e0 + len / 2) : 0;
        case (kill_sel)
            1:       kill_t = r0 + 3;
            2:       kill_t = b0 + len / 2;
            3:       kill_t = m0 + len / 2;
            default: kill_t = 0;
        endcase
        t_end  = (kill_t > 0) ? (kill_t + 4) : (dn + 1);
        n_wa = 0; n_wb = 0; n_done = 0; t_done = -1;

        @(posedge core_clk); #1;
        start = 1'b1; abort = 1'b0; finish = 1'b0; base_addr = base; token_len = LW'(len);
        @(negedge core_clk);
        chk("accept_busy", busy, 0);
        chk("accept_clr", {comp_rst, sum_clr}, (len != 0) ? 2'b11 : 2'b00);

        for (int t = 1; t <= t_end; t++) begin
            bit dead;
            logic e_rd, e_wr, e_ce, e_ate, e_reci, e_done, e_busy;
            logic [2:0] e_st;
            logic [AW-1:0] e_ra, e_wa;
            @(posedge core_clk); #1;
            start     = (t == dup_t);
            base_addr = AW'($urandom);
            token_len = LW'($urandom);
            abort     = !kill_rst && (t == kill_t);
            if (len == 0) finish = 1'b0;
            else finish = fin_hold ? (t >= r0 - 3) : (t == r0 + fin_k);
            if (kill_rst && t == kill_t) begin
                #2; rst_n = 1'b0; #1;
                chk("async_rst", outs(), 0);
            end
            if (kill_rst && t == kill_t + 1) rst_n = 1'b1;
            @(negedge core_clk);

            dead = (kill_t > 0) && ((t > kill_t) || (kill_rst && t == kill_t));
            e_rd = 0; e_wr = 0; e_ce = 0; e_ate = 0; e_reci = 0; e_st = ST_IDLE;
            e_ra = '0; e_wa = '0;
            if (len != 0) begin
                if (in_win(t, m0, len)) begin e_rd = 1; e_ra = base + AW'(t - m0); end
                if (in_win(t, e0, len)) begin e_rd = 1; e_ra = base + AW'(t - e0); end
                if (in_win(t, b0, len)) begin e_rd = 1; e_ra = base + AW'(t - b0); end
                e_ce = in_win(t - RD_LAT, m0, len);
                if (in_win(t - DA, e0, len)) begin e_wr = 1; e_ate = 1; e_wa = base + AW'(t - DA - e0); end
                if (in_win(t - DB, b0, len)) begin e_wr = 1; e_wa = base + AW'(t - DB - b0); end
                e_reci = (t == r0);
                if (t < e0)      e_st = ST_MAX;
                else if (t < r0) e_st = ST_A;
                else if (t < b0) e_st = ST_RECI;
                else if (t < dn) e_st = ST_B;
            end
            e_done = (t == dn);
            e_busy = (t <= dn);

            if (dead) begin
                chk($sformatf("killed@%0d", t), outs(), 0);
            end else begin
                chk($sformatf("rd_en@%0d", t), rd_en, e_rd);
                if (e_rd) chk($sformatf("rd_addr@%0d", t), rd_addr, e_ra);
                chk($sformatf("wr_en@%0d", t), wr_en, e_wr);
                if (e_wr) chk($sformatf("wr_addr@%0d", t), wr_addr, e_wa);
                chk($sformatf("comp_en@%0d", t), comp_en, e_ce);
                chk($sformatf("adder_en@%0d", t), adder_tree_en, e_ate);
                chk($sformatf("reci_en@%0d", t), reci_en, e_reci);
                chk($sformatf("done@%0d", t), done, e_done);
                chk($sformatf("busy@%0d", t), busy, e_busy);
                chk($sformatf("sm_state@%0d", t), sm_state, e_st);
                chk($sformatf("clr@%0d", t), {comp_rst, sum_clr}, 2'b00);
            end
            if (wr_en && t < r0) n_wa++;
            if (wr_en && t > r0) n_wb++;
            if (done) begin
                n_done++;
                if (t_done < 0) t_done = t;
            end
        end
        start = 1'b0; abort = 1'b0; finish = 1'b0;

        if (kill_t == 0) begin
            chk("done_cnt", n_done, 1);
            chk("wrA_cnt", n_wa, (len == 0) ? 0 : len);
            chk("wrB_cnt", n_wb, (len == 0) ? 0 : len);
            chk("latency", t_done, (len == 0) ? 1 :
                (len + RD_LAT + 1) + (len + DA + ADD_LAT) + 1 + w + (len + DB) + 1);
        end else begin
            chk("no_done", n_done, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge core_clk);
        @(negedge core_clk);
        chk("reset_outs", outs(), 0);
        @(posedge core_clk); #1;
        rst_n = 1'b1;
        @(negedge core_clk);
        chk("idle_outs", outs(), 0);

        // basic row, finish 5 cycles after the request
        run_op(10'h010, 4, 5, 1'b0, 1'b0, 0, 1'b0);
        // empty row
        run_op(10'h123, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        // address wrap
        run_op(10'h3FE, 4, 2, 1'b0, 1'b0, 0, 1'b0);
        // abort in RECI_WAIT, abort mid EXPB_RD, then a clean run
        run_op(10'h040, 4, 20, 1'b0, 1'b0, 1, 1'b0);
        run_op(10'h080, 4, 3, 1'b0, 1'b0, 2, 1'b0);
        run_op(10'h0C0, 4, 1, 1'b0, 1'b0, 0, 1'b0);
        // start during EXPA_RD is ignored
        run_op(10'h200, 6, 0, 1'b0, 1'b1, 0, 1'b0);
        // async reset mid MAX, then a clean run
        run_op(10'h300, 4, 2, 1'b0, 1'b0, 3, 1'b1);
        run_op(10'h301, 3, 4, 1'b0, 1'b0, 0, 1'b0);

        // abort and start together in IDLE: start is dropped
        @(posedge core_clk); #1;
        start = 1'b1; abort = 1'b1; base_addr = 10'h055; token_len = 10'd4;
        @(negedge core_clk);
        chk("abort_start_clr", {comp_rst, sum_clr}, 2'b00);
        @(posedge core_clk); #1;
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge core_clk);
            chk($sformatf("abort_start_idle%0d", i), outs(), 0);
        end

        // longest row with finish already high before the request
        run_op(10'h1F0, 511, 0, 1'b1, 1'b0, 0, 1'b0);

        // randomized rows
        for (int n = 0; n < 16; n++) begin
            int len, fk, ks;
            bit fh, dp;
            len = $urandom_range(1, 16);
            fk  = $urandom_range(0, 6);
            fh  = ($urandom_range(0, 3) == 0);
            ks  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            if (ks == 1) begin fk = 10; fh = 1'b0; end
            dp  = (ks == 0) && $urandom_range(0, 1) == 1;
            run_op(AW'($urandom), len, fk, fh, dp, ks, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
